// File: rtl/uivtm_if.sv
// rtl/uivtm_if.sv - signal bundle between a video source and the uivtm timing monitor
//
// Purpose: groups the video sync/data inputs, the clear strobe and all monitor
// results so the monitor exposes a single bus port.
//   master modport (source/host side): drives I_vtm_vs, I_vtm_hs, I_vtm_de,
//     I_vtm_data, I_vtm_clr; observes every O_* signal.
//   slave modport (uivtm side): the mirror image.
// CNT_W sets the width of the four geometry outputs.

interface uivtm_if #(
  parameter int CNT_W = 12
);
  logic             I_vtm_vs;
  logic             I_vtm_hs;
  logic             I_vtm_de;
  logic [23:0]      I_vtm_data;
  logic             I_vtm_clr;

  logic [CNT_W-1:0] O_h_total;
  logic [CNT_W-1:0] O_h_active;
  logic [CNT_W-1:0] O_v_total;
  logic [CNT_W-1:0] O_v_active;
  logic             O_meas_valid;
  logic             O_lock;
  logic             O_err;
  logic [15:0]      O_frame_cnt;
  logic [23:0]      O_chksum;

  modport master (
    output I_vtm_vs, I_vtm_hs, I_vtm_de, I_vtm_data, I_vtm_clr,
    input  O_h_total, O_h_active, O_v_total, O_v_active,
    input  O_meas_valid, O_lock, O_err, O_frame_cnt, O_chksum
  );

  modport slave (
    input  I_vtm_vs, I_vtm_hs, I_vtm_de, I_vtm_data, I_vtm_clr,
    output O_h_total, O_h_active, O_v_total, O_v_active,
    output O_meas_valid, O_lock, O_err, O_frame_cnt, O_chksum
  );
endinterface

// File: rtl/uivtm.sv
// rtl/uivtm.sv - video timing monitor: measures frame geometry and tracks lock
//
// Purpose: measures h_total/h_active/v_total/v_active of an incoming
// vs/hs/de video stream, publishes them once per frame and declares lock after
// LOCK_FRAMES identical measurements. A geometry change while locked raises a
// sticky error.
// Ports:
//   I_vtm_clk   - single clock, rising edge
//   I_vtm_rstn  - synchronous active-low reset
//   vtm         - uivtm_if.slave: video inputs, clear strobe, all results
// Parameters: LOCK_FRAMES (1..15), CNT_W (geometry counter width).
// Optional feature: define UIVTM_CHKSUM_EN to add a per-frame 24-bit pixel
// checksum on O_chksum that also takes part in the lock comparison; when
// undefined O_chksum is tied to 0.

module uivtm #(
  parameter int LOCK_FRAMES = 4,
  parameter int CNT_W       = 12
) (
  input  logic   I_vtm_clk,
  input  logic   I_vtm_rstn,
  uivtm_if.slave vtm
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]       LOCK_N  = LOCK_FRAMES[3:0];

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKING = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // input edge detection
  logic vs_q, vs_d;
  logic hs_q, hs_d;
  logic de_q, de_d;

  // running (per-frame) measurement state
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;          // clocks since last hs rise
  logic             hs_seen_q, hs_seen_d;      // an hs rise already seen this frame
  logic [CNT_W-1:0] h_tot_run_q, h_tot_run_d;  // last hs-to-hs distance in frame
  logic [CNT_W-1:0] de_cnt_q, de_cnt_d;        // length of current de run
  logic [CNT_W-1:0] h_act_run_q, h_act_run_d;  // last completed de run in frame
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;          // hs rises this frame
  logic [CNT_W-1:0] v_act_q, v_act_d;          // de rises this frame

  // published results and control
  state_t           state_q, state_d;
  logic [3:0]       match_q, match_d;
  logic [CNT_W-1:0] h_total_q, h_total_d;
  logic [CNT_W-1:0] h_active_q, h_active_d;
  logic [CNT_W-1:0] v_total_q, v_total_d;
  logic [CNT_W-1:0] v_active_q, v_active_d;
  logic             meas_valid_q, meas_valid_d;
  logic             lock_q, lock_d;
  logic             err_q, err_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;

  logic vs_rise, hs_rise, de_rise, de_fall, frame_start;
  logic [CNT_W-1:0] meas_h_act;
  logic geom_match, meas_match;

  assign vs_rise     = vtm.I_vtm_vs & ~vs_q;
  assign hs_rise     = vtm.I_vtm_hs & ~hs_q;
  assign de_rise     = vtm.I_vtm_de & ~de_q;
  assign de_fall     = ~vtm.I_vtm_de & de_q;
  assign frame_start = vs_rise;

  // A de run whose falling edge coincides with the frame start ended on the
  // previous clock, so it still belongs to the frame being closed.
  assign meas_h_act = de_fall ? de_cnt_q : h_act_run_q;

  assign geom_match = (h_tot_run_q == h_total_q) && (meas_h_act == h_active_q) &&
                      (v_cnt_q == v_total_q) && (v_act_q == v_active_q);

`ifdef UIVTM_CHKSUM_EN
  logic [23:0] sum_q, sum_d;   // running pixel sum of the current frame
  logic [23:0] chk_q, chk_d;   // published checksum of the last frame

  always_comb begin
    sum_d = sum_q;
    chk_d = chk_q;
    if (frame_start) begin
      // the start cycle's pixel belongs to the new frame
      sum_d = vtm.I_vtm_de ? vtm.I_vtm_data : 24'd0;
      if (state_q != SEARCH) chk_d = sum_q;
    end else if (vtm.I_vtm_de) begin
      sum_d = sum_q + vtm.I_vtm_data;
    end
  end

  always_ff @(posedge I_vtm_clk) begin
    if (!I_vtm_rstn) begin
      sum_q <= '0;
      chk_q <= '0;
    end else begin
      sum_q <= sum_d;
      chk_q <= chk_d;
    end
  end

  assign meas_match   = geom_match && (sum_q == chk_q);
  assign vtm.O_chksum = chk_q;
`else
  logic [23:0] data_unused;
  assign data_unused  = vtm.I_vtm_data;
  assign meas_match   = geom_match;
  assign vtm.O_chksum = 24'd0;
`endif

  // running counters
  always_comb begin
    vs_d = vtm.I_vtm_vs;
    hs_d = vtm.I_vtm_hs;
    de_d = vtm.I_vtm_de;

    // hs rise cycle is clock 0 of the new line, so the next cycle reads 1
    h_cnt_d = hs_rise ? CNT_ONE : sat_inc(h_cnt_q);

    hs_seen_d   = hs_seen_q | hs_rise;
    h_tot_run_d = h_tot_run_q;
    if (hs_rise && hs_seen_q) h_tot_run_d = h_cnt_q;

    if (!vtm.I_vtm_de)  de_cnt_d = '0;
    else if (de_rise)   de_cnt_d = CNT_ONE;
    else                de_cnt_d = sat_inc(de_cnt_q);

    h_act_run_d = de_fall ? de_cnt_q : h_act_run_q;

    v_cnt_d = hs_rise ? sat_inc(v_cnt_q) : v_cnt_q;
    v_act_d = de_rise ? sat_inc(v_act_q) : v_act_q;

    if (frame_start) begin
      // events on the start cycle itself are the first of the new frame;
      // a new frame cannot yet have a line-to-line distance
      hs_seen_d   = hs_rise;
      h_tot_run_d = '0;
      h_act_run_d = '0;
      v_cnt_d     = hs_rise ? CNT_ONE : '0;
      v_act_d     = de_rise ? CNT_ONE : '0;
    end
  end

  // lock tracking and result publication
  always_comb begin
    state_d      = state_q;
    match_d      = match_q;
    h_total_d    = h_total_q;
    h_active_d   = h_active_q;
    v_total_d    = v_total_q;
    v_active_d   = v_active_q;
    meas_valid_d = 1'b0;
    err_d        = err_q;
    frame_cnt_d  = frame_cnt_q;

    if (vtm.I_vtm_clr) begin
      err_d       = 1'b0;
      frame_cnt_d = 16'd0;
    end

    if (frame_start) begin
      frame_cnt_d = vtm.I_vtm_clr ? 16'd1 : frame_cnt_q + 16'd1;

      // the first frame start only opens a measurement window
      if (state_q != SEARCH) begin
        h_total_d    = h_tot_run_q;
        h_active_d   = meas_h_act;
        v_total_d    = v_cnt_q;
        v_active_d   = v_act_q;
        meas_valid_d = 1'b1;
      end

      case (state_q)
        SEARCH: begin
          state_d = MEASURE;
        end
        MEASURE: begin
          match_d = 4'd1;
          state_d = (LOCK_N <= 4'd1) ? LOCKED : LOCKING;
        end
        LOCKING: begin
          if (meas_match) begin
            match_d = match_q + 4'd1;
            if (match_q + 4'd1 >= LOCK_N) state_d = LOCKED;
          end else begin
            match_d = 4'd1;
          end
        end
        LOCKED: begin
          // set after the clear so a change is never lost to a coincident clr
          if (!meas_match) begin
            err_d   = 1'b1;
            match_d = 4'd1;
            state_d = LOCKING;
          end
        end
        default: state_d = SEARCH;
      endcase
    end

    lock_d = (state_d == LOCKED);
  end

  always_ff @(posedge I_vtm_clk) begin
    if (!I_vtm_rstn) begin
      vs_q         <= 1'b0;
      hs_q         <= 1'b0;
      de_q         <= 1'b0;
      h_cnt_q      <= '0;
      hs_seen_q    <= 1'b0;
      h_tot_run_q  <= '0;
      de_cnt_q     <= '0;
      h_act_run_q  <= '0;
      v_cnt_q      <= '0;
      v_act_q      <= '0;
      state_q      <= SEARCH;
      match_q      <= 4'd0;
      h_total_q    <= '0;
      h_active_q   <= '0;
      v_total_q    <= '0;
      v_active_q   <= '0;
      meas_valid_q <= 1'b0;
      lock_q       <= 1'b0;
      err_q        <= 1'b0;
      frame_cnt_q  <= 16'd0;
    end else begin
      vs_q         <= vs_d;
      hs_q         <= hs_d;
      de_q         <= de_d;
      h_cnt_q      <= h_cnt_d;
      hs_seen_q    <= hs_seen_d;
      h_tot_run_q  <= h_tot_run_d;
      de_cnt_q     <= de_cnt_d;
      h_act_run_q  <= h_act_run_d;
      v_cnt_q      <= v_cnt_d;
      v_act_q      <= v_act_d;
      state_q      <= state_d;
      match_q      <= match_d;
      h_total_q    <= h_total_d;
      h_active_q   <= h_active_d;
      v_total_q    <= v_total_d;
      v_active_q   <= v_active_d;
      meas_valid_q <= meas_valid_d;
      lock_q       <= lock_d;
      err_q        <= err_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign vtm.O_h_total    = h_total_q;
  assign vtm.O_h_active   = h_active_q;
  assign vtm.O_v_total    = v_total_q;
  assign vtm.O_v_active   = v_active_q;
  assign vtm.O_meas_valid = meas_valid_q;
  assign vtm.O_lock       = lock_q;
  assign vtm.O_err        = err_q;
  assign vtm.O_frame_cnt  = frame_cnt_q;

endmodule
